// File: rtl/nav_spi_responder.sv
// nav_spi_responder: SPI mode-3 register responder (64 x 8) with a local register port.
// Optional feature: define NAV_SPI_AUTOINC_EN to honour the MS (auto-increment) command bit.
`default_nettype none

module nav_spi_responder #(
   parameter logic [5:0] WHO_AM_I_ADDR = 6'h0F,
   parameter logic [7:0] WHO_AM_I_VAL  = 8'h68
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       sclk,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic       lcl_we,
   input  logic [5:0] lcl_addr,
   input  logic [7:0] lcl_wdata,
   output logic [7:0] lcl_rdata,
   output logic       it,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} state_t;

   state_t     state, state_nx;
   logic       cs_m, cs_s, cs_d;
   logic       sclk_m, sclk_s, sclk_d;
   logic       mosi_m, mosi_s;
   logic [2:0] bit_cnt;
   logic [6:0] rx_sr;
   logic [7:0] tx_sr;
   logic [5:0] addr;
   logic       ms;
   logic       miso_r;
   logic [7:0] regs [64];

   logic       cs_fall, cs_rise, sclk_rise, sclk_fall, byte_done, ms_bit, spi_we;
   logic [7:0] rx_byte, load_data;
   logic [5:0] addr_nx, load_addr;

   always_ff @(posedge clk) begin
      if (!rst) begin
         {cs_m, cs_s, cs_d}       <= 3'b111;
         {sclk_m, sclk_s, sclk_d} <= 3'b111;
         {mosi_m, mosi_s}         <= 2'b00;
      end else begin
         {cs_m, cs_s, cs_d}       <= {cs, cs_m, cs_s};
         {sclk_m, sclk_s, sclk_d} <= {sclk, sclk_m, sclk_s};
         {mosi_m, mosi_s}         <= {mosi, mosi_m};
      end
   end

   assign cs_fall   = cs_d & ~cs_s;
   assign cs_rise   = ~cs_d & cs_s;
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign rx_byte   = {rx_sr, mosi_s};
   assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE) && !cs_rise;
   assign spi_we    = byte_done && (state == WDATA);
   assign addr_nx   = ms ? addr + 6'd1 : addr;

`ifdef NAV_SPI_AUTOINC_EN
   assign ms_bit = rx_byte[6];
`else
   assign ms_bit = 1'b0;
`endif

   // Transmit load is write-first so a same-cycle local write is visible to SPI reads.
   assign load_addr = (state == CMD) ? rx_byte[5:0] : addr_nx;
   always_comb begin
      load_data = regs[load_addr];
      if (load_addr == WHO_AM_I_ADDR)
         load_data = WHO_AM_I_VAL;
      else if (lcl_we && (lcl_addr == load_addr))
         load_data = lcl_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (cs_fall) state_nx = CMD;
         CMD:     if (byte_done) state_nx = rx_byte[7] ? RDATA : WDATA;
         default: state_nx = state;
      endcase
      if (cs_rise)
         state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bit_cnt <= 3'd0;
         rx_sr   <= 7'd0;
         tx_sr   <= 8'd0;
         addr    <= 6'd0;
         ms      <= 1'b0;
         miso_r  <= 1'b0;
         it      <= 1'b0;
      end else begin
         it <= 1'b0;
         // A chip-select release discards any partial byte.
         if (cs_rise || state == IDLE) begin
            bit_cnt <= 3'd0;
         end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sr   <= rx_byte[6:0];
         end
         if (state == RDATA && sclk_fall && !cs_rise) begin
            miso_r <= tx_sr[7];
            tx_sr  <= {tx_sr[6:0], 1'b0};
         end
         if (state != RDATA)
            miso_r <= 1'b0;
         if (byte_done) begin
            case (state)
               CMD: begin
                  addr <= rx_byte[5:0];
                  ms   <= ms_bit;
                  if (rx_byte[7])
                     tx_sr <= load_data;
               end
               WDATA: begin
                  it   <= 1'b1;
                  addr <= addr_nx;
               end
               RDATA: begin
                  addr  <= addr_nx;
                  tx_sr <= load_data;
               end
               default: ;
            endcase
         end
      end
   end

   // SPI write is issued last so it wins a same-address collision with lcl_we.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 64; i++)
            regs[i] <= 8'd0;
      end else begin
         if (lcl_we && (lcl_addr != WHO_AM_I_ADDR))
            regs[lcl_addr] <= lcl_wdata;
         if (spi_we && (addr != WHO_AM_I_ADDR))
            regs[addr] <= rx_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         lcl_rdata <= 8'd0;
      else
         lcl_rdata <= (lcl_addr == WHO_AM_I_ADDR) ? WHO_AM_I_VAL : regs[lcl_addr];
   end

   assign miso_oe = (state == RDATA);
   assign miso    = miso_r & miso_oe;
   assign busy    = ~cs_s;

endmodule

`default_nettype wire
